// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  // Operation encoding; every 3-bit value is a legal operation.
  typedef enum logic [OP_W-1:0] {
    OpNot  = 3'd0,
    OpAnd  = 3'd1,
    OpOr   = 3'd2,
    OpXor  = 3'd3,
    OpNand = 3'd4,
    OpNor  = 3'd5,
    OpXnor = 3'd6,
    OpPass = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation core: result plus zero and parity flags.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  // Decode the operation; b is simply unused by the unary ops.
  always_comb begin
    y = '0;
    unique case (op_e'(op))
      OpNot:  y = ~a;
      OpAnd:  y = a & b;
      OpOr:   y = a | b;
      OpXor:  y = a ^ b;
      OpNand: y = ~(a & b);
      OpNor:  y = ~(a | b);
      OpXnor: y = ~(a ^ b);
      OpPass: y = a;
    endcase
  end

  // Flags derived from the result.
  always_comb begin
    zero   = (y == '0);
    parity = ^y;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a valid/ready input, an output register and one skid entry.
// in_ready is registered, so upstream never sees a combinational path from out_ready.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               parity,
  output logic [COUNT_W-1:0] op_count
);

  // Entry layout: {y, zero, parity}.
  localparam int unsigned EntW = WIDTH + 2;

  logic [WIDTH-1:0]   core_y;
  logic               core_zero;
  logic               core_parity;
  logic [EntW-1:0]    res;

  logic [EntW-1:0]    or_data_q, or_data_d;
  logic               or_valid_q, or_valid_d;
  logic [EntW-1:0]    sk_data_q, sk_data_d;
  logic               sk_valid_q, sk_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic pop;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .y      (core_y),
    .zero   (core_zero),
    .parity (core_parity)
  );

  assign res    = {core_y, core_zero, core_parity};
  assign accept = in_valid && in_ready_q;
  assign pop    = or_valid_q && out_ready;

  // Next state of the two-entry buffer. SK is only ever filled while OR is stalled,
  // and in_ready_q guarantees no accept arrives while SK is occupied.
  always_comb begin
    or_data_d  = or_data_q;
    or_valid_d = or_valid_q;
    sk_data_d  = sk_data_q;
    sk_valid_d = sk_valid_q;
    if (pop) begin
      if (sk_valid_q) begin
        or_data_d  = sk_data_q;
        or_valid_d = 1'b1;
        if (accept) begin
          sk_data_d  = res;
          sk_valid_d = 1'b1;
        end else begin
          sk_valid_d = 1'b0;
        end
      end else if (accept) begin
        or_data_d  = res;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (or_valid_q) begin
        sk_data_d  = res;
        sk_valid_d = 1'b1;
      end else begin
        or_data_d  = res;
        or_valid_d = 1'b1;
      end
    end
    in_ready_d = !sk_valid_d;
  end

  // Saturating count of accepted operations.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_data_q  <= '0;
      or_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      or_data_q  <= or_data_d;
      or_valid_q <= or_valid_d;
      sk_data_q  <= sk_data_d;
      sk_valid_q <= sk_valid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign y         = or_data_q[EntW-1:2];
  assign zero      = or_data_q[1];
  assign parity    = or_data_q[0];
  assign op_count  = cnt_q;

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 1..64).
REQ-002 Parameter COUNT_W, default 16, width of the accepted-operation counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 op  input  3  operation select, encoding per REQ-012.
REQ-008 a, b  input  WIDTH each  operands; b ignored for unary ops.
REQ-009 out_valid  output  1  y/zero/parity hold a valid result.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 y  output  WIDTH  result. zero  output  1  y == 0. parity  output  1  XOR-reduction of y. op_count  output  COUNT_W  accepted-operation count.

Function
REQ-012 Op encoding: 0 NOT a; 1 a AND b; 2 a OR b; 3 a XOR b; 4 NAND; 5 NOR; 6 XNOR; 7 PASS a; all bitwise over WIDTH bits.
REQ-013 Transfer in: in_valid && in_ready at a rising edge; op/a/b sampled only then.
REQ-014 Transfer out: out_valid && out_ready at a rising edge.
REQ-015 Storage: output register (OR) plus one skid register (SK), each holding {y, zero, parity} and a valid bit; total 2 entries.
REQ-016 Latency: result of an accepted op appears on y with out_valid=1 on the cycle after acceptance if OR is free or being popped in the same cycle.
REQ-017 If OR holds an unconsumed result (out_valid && !out_ready) and a new op is accepted, the new result goes to SK.
REQ-018 On an out-transfer with SK valid: OR loads SK; SK loads the new result if an op is accepted in the same cycle, else SK becomes empty.
REQ-019 On an out-transfer with SK empty: OR loads the new result if one is accepted, else out_valid falls to 0.
REQ-020 in_ready is registered: 1 exactly when SK will be empty next cycle; never combinationally depends on out_ready.
REQ-021 Results leave in acceptance order; no result dropped or duplicated.
REQ-022 y/zero/parity stay stable while out_valid && !out_ready.
REQ-023 op_count increments by 1 per in-transfer, saturates at 2^COUNT_W-1 (no wrap).
REQ-024 No in-transfer occurs with both entries full (in_ready=0); in_valid then ignored.

Reset
REQ-025 While rst_n=0 at an edge: out_valid=0, y=0, zero=0, parity=0, SK invalid, op_count=0, in_ready=0.
REQ-026 in_ready rises to 1 on the first edge with rst_n=1.
REQ-027 Reset mid-operation discards OR and SK contents; no transfer completes on a reset edge.

Structure
REQ-028 Package logic_unit_pkg holds the op enumeration typedef and constant OP_W=3.
REQ-029 Combinational sub-module logic_op_core (op, a, b -> y, zero, parity) computes the result; logic_unit_pipe holds all state.

Verification (WIDTH=8, COUNT_W=4)
REQ-030 After reset, op=0 a=8'h0F, out_ready=1 -> next cycle y=8'hF0, zero=0, parity=0, op_count=1.
REQ-031 op=3 a=8'hAA b=8'hAA -> y=8'h00, zero=1, parity=0; op=1 a=8'hF3 b=8'h3F -> y=8'h33, parity=0.
REQ-032 out_ready=0, send ops NOT 8'h00, PASS 8'h01, third offered -> in_ready=0 after second accept; then out_ready=1 -> y=8'hFF then 8'h01 in order, in_ready back to 1.
REQ-033 Random in_valid/out_ready toggling, 200 ops -> scoreboard matches in order, no loss, outputs stable while stalled.
REQ-034 20 ops accepted -> op_count=4'hF held, no wrap.
REQ-035 rst_n=0 with both entries full -> next edge out_valid=0, in_ready=0, op_count=0; first edge after release in_ready=1.
